// File: rtl/ahb_master.sv
// ahb_master: AHB-Lite single-transfer initiator.
// Turns a valid/ready command stream into pipelined NONSEQ transfers.
// Every accepted command gets exactly one in-order response, including
// slave errors, data-phase timeouts and cancelled address phases.
module ahb_master #(
   parameter int unsigned ADDR_WIDTH = 4,
   parameter int unsigned TIMEOUT    = 16
) (
   input  logic                  clk,
   input  logic                  rst,
   // command stream
   input  logic                  cmd_valid,
   output logic                  cmd_ready,
   input  logic                  cmd_write,
   input  logic [ADDR_WIDTH-1:0] cmd_addr,
   input  logic [1:0]            cmd_size,
   input  logic [31:0]           cmd_wdata,
   // response stream
   output logic                  rsp_valid,
   output logic [31:0]           rsp_rdata,
   output logic                  rsp_error,
   output logic                  busy,
   // AHB-Lite master port
   output logic                  hsel,
   output logic [ADDR_WIDTH-1:0] haddr,
   output logic [1:0]            htrans,
   output logic [1:0]            hsize,
   output logic                  hwrite,
   output logic [2:0]            hburst,
   output logic [31:0]           hwdata,
   input  logic [31:0]           hrdata,
   input  logic                  hready,
   input  logic                  hresp
);

   localparam int unsigned TW          = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;
   localparam logic [1:0]  HTRANS_IDLE = 2'b00;
   localparam logic [1:0]  HTRANS_NSEQ = 2'b10;

   typedef enum logic [1:0] {
      RUN    = 2'd0,
      ERR    = 2'd1,
      CANCEL = 2'd2
   } state_t;

   state_t                state;

   // address-phase stage
   logic                  ap_valid;
   logic                  ap_write;
   logic [ADDR_WIDTH-1:0] ap_addr;
   logic [1:0]            ap_size;
   logic [31:0]           ap_wdata;

   // data-phase stage
   logic                  dp_valid;
   logic                  dp_write;
   logic [31:0]           dp_wdata;

   // an address-phase command was dropped and still owes an error response
   logic                  cancel_pend;
   logic [TW-1:0]         tmo_cnt;

   logic                  tmo_fire;
   logic                  cmd_fire;
   logic [1:0]            size_clamp;

   // Timeout fires on the TIMEOUT-th consecutive wait cycle of a data phase
   generate
      if (TIMEOUT != 0) begin : g_tmo
         assign tmo_fire = (state == RUN) && dp_valid && !hready && !hresp &&
                           (tmo_cnt == TW'(TIMEOUT - 1));
      end else begin : g_no_tmo
         assign tmo_fire = 1'b0;
      end
   endgenerate

   // Accept while the address slot frees this edge; hold off on the abort
   // edge so the bus really idles for a cycle after a timeout
   assign cmd_ready  = (state == RUN) && !hresp && (!ap_valid || hready) && !tmo_fire;
   assign cmd_fire   = cmd_valid && cmd_ready;
   assign size_clamp = (cmd_size == 2'd3) ? 2'd2 : cmd_size;

   // Bus drive decoded from the pipeline registers only
   assign htrans = ((state == RUN) && ap_valid) ? HTRANS_NSEQ : HTRANS_IDLE;
   assign haddr  = ap_valid ? ap_addr  : '0;
   assign hsize  = ap_valid ? ap_size  : 2'd0;
   assign hwrite = ap_valid && ap_write;
   assign hsel   = ap_valid || dp_valid;
   assign hburst = 3'b000;
   assign hwdata = (dp_valid && dp_write) ? dp_wdata : 32'h0;
   assign busy   = ap_valid || dp_valid || cancel_pend || (state != RUN);

   // Pipeline, FSM, timeout counter and response generation
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state       <= RUN;
         ap_valid    <= 1'b0;
         ap_write    <= 1'b0;
         ap_addr     <= '0;
         ap_size     <= 2'd0;
         ap_wdata    <= 32'h0;
         dp_valid    <= 1'b0;
         dp_write    <= 1'b0;
         dp_wdata    <= 32'h0;
         cancel_pend <= 1'b0;
         tmo_cnt     <= '0;
         rsp_valid   <= 1'b0;
         rsp_rdata   <= 32'h0;
         rsp_error   <= 1'b0;
      end else begin
         rsp_valid <= 1'b0;
         rsp_error <= 1'b0;
         rsp_rdata <= 32'h0;
         case (state)
            RUN: begin
               if (dp_valid && hresp && !hready) begin
                  // first error cycle: drop the address phase behind it
                  state   <= ERR;
                  tmo_cnt <= '0;
                  if (ap_valid) begin
                     cancel_pend <= 1'b1;
                     ap_valid    <= 1'b0;
                  end
               end else if (tmo_fire) begin
                  // slave hung: abort the data phase and any queued address
                  rsp_valid <= 1'b1;
                  rsp_error <= 1'b1;
                  dp_valid  <= 1'b0;
                  tmo_cnt   <= '0;
                  if (ap_valid) begin
                     cancel_pend <= 1'b1;
                     ap_valid    <= 1'b0;
                     state       <= CANCEL;
                  end
               end else if (hready) begin
                  // phase advance; a lone hresp with hready is an error completion
                  tmo_cnt   <= '0;
                  rsp_valid <= dp_valid;
                  rsp_error <= dp_valid && hresp;
                  if (dp_valid && !dp_write && !hresp) begin
                     rsp_rdata <= hrdata;
                  end
                  dp_valid <= ap_valid;
                  dp_write <= ap_write;
                  dp_wdata <= ap_wdata;
                  ap_valid <= cmd_fire;
                  if (cmd_fire) begin
                     ap_write <= cmd_write;
                     ap_addr  <= cmd_addr;
                     ap_size  <= size_clamp;
                     ap_wdata <= cmd_wdata;
                  end
               end else begin
                  // wait state: stages hold, an empty address slot may still fill
                  if (dp_valid) begin
                     tmo_cnt <= tmo_cnt + TW'(1);
                  end
                  if (cmd_fire) begin
                     ap_valid <= 1'b1;
                     ap_write <= cmd_write;
                     ap_addr  <= cmd_addr;
                     ap_size  <= size_clamp;
                     ap_wdata <= cmd_wdata;
                  end
               end
            end
            ERR: begin
               if (hready) begin
                  rsp_valid <= 1'b1;
                  rsp_error <= 1'b1;
                  dp_valid  <= 1'b0;
                  state     <= cancel_pend ? CANCEL : RUN;
               end
            end
            CANCEL: begin
               rsp_valid   <= 1'b1;
               rsp_error   <= 1'b1;
               cancel_pend <= 1'b0;
               state       <= RUN;
            end
            default: begin
               state <= RUN;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_ahb_master.sv
// tb_ahb_master: scoreboarded bench for ahb_master with a small bus-side
// slave model (16-word memory) and scripted hready/hresp sequences.
module tb_ahb_master;

   localparam int unsigned AW  = 4;
   localparam int unsigned TMO = 4;

   logic          clk = 1'b0;
   logic          rst;
   logic          cmd_valid;
   logic          cmd_ready;
   logic          cmd_write;
   logic [AW-1:0] cmd_addr;
   logic [1:0]    cmd_size;
   logic [31:0]   cmd_wdata;
   logic          rsp_valid;
   logic [31:0]   rsp_rdata;
   logic          rsp_error;
   logic          busy;
   logic          hsel;
   logic [AW-1:0] haddr;
   logic [1:0]    htrans;
   logic [1:0]    hsize;
   logic          hwrite;
   logic [2:0]    hburst;
   logic [31:0]   hwdata;
   logic [31:0]   hrdata;
   logic          hready;
   logic          hresp;

   typedef struct {
      logic          write;
      logic [AW-1:0] addr;
      logic [1:0]    size;
      logic [31:0]   wdata;
      logic [1:0]    exp_size;
      logic [31:0]   exp_rdata;
   } vec_t;

   typedef struct {
      logic [AW-1:0] addr;
      logic [1:0]    size;
      logic          write;
      logic [31:0]   wdata;
   } ap_exp_t;

   typedef struct {
      logic [31:0] rdata;
      logic        err;
   } rsp_exp_t;

   typedef struct packed {
      logic          act;
      logic          write;
      logic [AW-1:0] addr;
      logic [31:0]   wdata;
   } slv_dp_t;

   ap_exp_t     apq[$];
   rsp_exp_t    rspq[$];
   logic [31:0] mem [16];
   slv_dp_t     s_dp;
   slv_dp_t     s_nxt;
   int          n_vec  = 0;
   int          n_miss = 0;

   ahb_master #(.ADDR_WIDTH(AW), .TIMEOUT(TMO)) dut (
      .clk       (clk),
      .rst       (rst),
      .cmd_valid (cmd_valid),
      .cmd_ready (cmd_ready),
      .cmd_write (cmd_write),
      .cmd_addr  (cmd_addr),
      .cmd_size  (cmd_size),
      .cmd_wdata (cmd_wdata),
      .rsp_valid (rsp_valid),
      .rsp_rdata (rsp_rdata),
      .rsp_error (rsp_error),
      .busy      (busy),
      .hsel      (hsel),
      .haddr     (haddr),
      .htrans    (htrans),
      .hsize     (hsize),
      .hwrite    (hwrite),
      .hburst    (hburst),
      .hwdata    (hwdata),
      .hrdata    (hrdata),
      .hready    (hready),
      .hresp     (hresp)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_miss++;
         $display("FAIL %s: got 0x%08h, want 0x%08h at %0t", name, act, exp, $time);
      end
   endtask

   // Slave read data for the current data phase
   assign hrdata = (s_dp.act && !s_dp.write) ? mem[s_dp.addr] : 32'h0;

   always @(posedge clk or posedge rst) begin
      if (rst) s_dp <= '0;
      else     s_dp <= s_nxt;
   end

   // Mid-cycle monitor: address phase, data phase and response scoreboards
   always @(negedge clk) begin
      ap_exp_t  ea;
      rsp_exp_t er;
      if (rst) begin
         s_nxt = '0;
      end else begin
         if (s_dp.act && s_dp.write) begin
            chk("hwdata", hwdata, s_dp.wdata);
            if (hready && !hresp) mem[s_dp.addr] = hwdata;
         end
         s_nxt = s_dp;
         if (hready) s_nxt.act = 1'b0;
         if (htrans == 2'b10 && hready) begin
            if (apq.size() == 0) begin
               n_vec++;
               n_miss++;
               $display("FAIL ap_unexpected: got NONSEQ at 0x%0h, want none at %0t", haddr, $time);
            end else begin
               ea = apq.pop_front();
               chk("haddr", 32'(haddr), 32'(ea.addr));
               chk("hsize", 32'(hsize), 32'(ea.size));
               chk("hwrite", 32'(hwrite), 32'(ea.write));
               s_nxt.act   = 1'b1;
               s_nxt.write = ea.write;
               s_nxt.addr  = haddr;
               s_nxt.wdata = ea.wdata;
            end
         end
         if (rsp_valid) begin
            if (rspq.size() == 0) begin
               n_vec++;
               n_miss++;
               $display("FAIL rsp_unexpected: got rsp_valid=1, want 0 at %0t", $time);
            end else begin
               er = rspq.pop_front();
               chk("rsp_rdata", rsp_rdata, er.rdata);
               chk("rsp_error", 32'(rsp_error), 32'(er.err));
            end
         end
      end
   end

   // Present one command from posedge+1; returns at posedge+1 after acceptance
   task automatic send(input logic w, input logic [AW-1:0] a, input logic [1:0] sz,
                       input logic [31:0] wd, input logic [1:0] esz, input logic [31:0] erd,
                       input logic eerr, input bit p_ap, input bit p_rsp, output int waited);
      rsp_exp_t r;
      ap_exp_t  e;
      cmd_valid = 1'b1;
      cmd_write = w;
      cmd_addr  = a;
      cmd_size  = sz;
      cmd_wdata = wd;
      waited    = 0;
      @(negedge clk);
      while (!cmd_ready && waited < 50) begin
         waited++;
         @(negedge clk);
      end
      if (!cmd_ready) begin
         n_vec++;
         n_miss++;
         $display("FAIL cmd_accept: got no cmd_ready in %0d cycles, want accept", waited);
      end else begin
         r.rdata = erd;
         r.err   = eerr;
         if (p_rsp) rspq.push_back(r);
         e.addr  = a;
         e.size  = esz;
         e.write = w;
         e.wdata = wd;
         if (p_ap) apq.push_back(e);
      end
      @(posedge clk);
      #1;
      cmd_valid = 1'b0;
   endtask

   task automatic drain();
      int n = 0;
      while (rspq.size() != 0 && n < 30) begin
         @(negedge clk);
         n++;
      end
      chk("rsp_drain", 32'(rspq.size()), 32'd0);
      chk("ap_drain", 32'(apq.size()), 32'd0);
   endtask

   task automatic idle(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: got timeout, want $finish");
      $fatal(1, "watchdog");
   end

   initial begin
      vec_t tbl [10];
      int   w0, w1, w2;
      rst       = 1'b1;
      cmd_valid = 1'b0;
      cmd_write = 1'b0;
      cmd_addr  = '0;
      cmd_size  = 2'd0;
      cmd_wdata = 32'h0;
      hready    = 1'b1;
      hresp     = 1'b0;
      for (int i = 0; i < 16; i++) mem[i] = 32'hC0DE_0000 | 32'(i);
      mem[0] = 32'h11;
      mem[4] = 32'h22;
      mem[8] = 32'h33;

      tbl[0] = '{1'b0, 4'd0,  2'd2, 32'h0,         2'd2, 32'h11};
      tbl[1] = '{1'b0, 4'd4,  2'd2, 32'h0,         2'd2, 32'h22};
      tbl[2] = '{1'b0, 4'd8,  2'd2, 32'h0,         2'd2, 32'h33};
      tbl[3] = '{1'b1, 4'd0,  2'd2, 32'hDEADBEEF,  2'd2, 32'h0};
      tbl[4] = '{1'b0, 4'd0,  2'd0, 32'h0,         2'd0, 32'hDEADBEEF};
      tbl[5] = '{1'b1, 4'd3,  2'd3, 32'h12345678,  2'd2, 32'h0};
      tbl[6] = '{1'b0, 4'd3,  2'd1, 32'h0,         2'd1, 32'h12345678};
      tbl[7] = '{1'b1, 4'd15, 2'd1, 32'h0000ABCD,  2'd1, 32'h0};
      tbl[8] = '{1'b0, 4'd15, 2'd2, 32'h0,         2'd2, 32'h0000ABCD};
      tbl[9] = '{1'b0, 4'd7,  2'd2, 32'h0,         2'd2, 32'hC0DE0007};

      // reset values
      repeat (2) @(negedge clk);
      chk("rst_htrans", 32'(htrans), 32'd0);
      chk("rst_hsel", 32'(hsel), 32'd0);
      chk("rst_haddr", 32'(haddr), 32'd0);
      chk("rst_hsize", 32'(hsize), 32'd0);
      chk("rst_hwrite", 32'(hwrite), 32'd0);
      chk("rst_hburst", 32'(hburst), 32'd0);
      chk("rst_hwdata", hwdata, 32'h0);
      chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
      chk("rst_rsp_rdata", rsp_rdata, 32'h0);
      chk("rst_rsp_error", 32'(rsp_error), 32'd0);
      chk("rst_busy", 32'(busy), 32'd0);
      chk("rst_cmd_ready", 32'(cmd_ready), 32'd1);
      idle(1);
      rst = 1'b0;
      idle(2);

      // back-to-back zero-wait table
      for (int i = 0; i < 10; i++) begin
         send(tbl[i].write, tbl[i].addr, tbl[i].size, tbl[i].wdata, tbl[i].exp_size,
              tbl[i].exp_rdata, 1'b0, 1'b1, 1'b1, w0);
         chk("b2b_cmd_ready", 32'(w0), 32'd0);
      end
      drain();
      idle(2);

      // single write latency
      send(1'b1, 4'd0, 2'd2, 32'hDEADBEEF, 2'd2, 32'h0, 1'b0, 1'b1, 1'b1, w0);
      @(negedge clk);
      chk("lat_c1_htrans", 32'(htrans), 32'd2);
      chk("lat_c1_haddr", 32'(haddr), 32'd0);
      chk("lat_c1_hsize", 32'(hsize), 32'd2);
      chk("lat_c1_hsel", 32'(hsel), 32'd1);
      @(negedge clk);
      chk("lat_c2_hwdata", hwdata, 32'hDEADBEEF);
      chk("lat_c2_htrans", 32'(htrans), 32'd0);
      chk("lat_c2_rsp_valid", 32'(rsp_valid), 32'd0);
      @(negedge clk);
      chk("lat_c3_rsp_valid", 32'(rsp_valid), 32'd1);
      chk("lat_c3_rsp_error", 32'(rsp_error), 32'd0);
      drain();
      idle(2);

      // three wait states in the write data phase, read queued behind it
      fork
         begin
            send(1'b1, 4'd2, 2'd2, 32'hCAFE0002, 2'd2, 32'h0, 1'b0, 1'b1, 1'b1, w0);
            send(1'b0, 4'd2, 2'd2, 32'h0, 2'd2, 32'hCAFE0002, 1'b0, 1'b1, 1'b1, w1);
            send(1'b0, 4'd9, 2'd2, 32'h0, 2'd2, 32'hC0DE0009, 1'b0, 1'b1, 1'b1, w2);
         end
         begin
            for (int c = 1; c <= 6; c++) begin
               @(posedge clk);
               #1;
               hready = (c >= 2 && c <= 4) ? 1'b0 : 1'b1;
               @(negedge clk);
               if (c >= 2 && c <= 5) chk("wait_hwdata", hwdata, 32'hCAFE0002);
               if (c >= 2 && c <= 4) chk("wait_cmd_ready", 32'(cmd_ready), 32'd0);
               if (c == 5) chk("wait_c5_rsp_valid", 32'(rsp_valid), 32'd0);
               if (c == 6) chk("wait_c6_rsp_valid", 32'(rsp_valid), 32'd1);
            end
         end
      join
      chk("wait_stall_cycles", 32'(w2), 32'd3);
      drain();
      idle(2);

      // two-cycle error on write 5 with read 8 in the address phase
      fork
         begin
            send(1'b1, 4'd5, 2'd2, 32'h00000055, 2'd2, 32'h0, 1'b1, 1'b1, 1'b1, w0);
            send(1'b0, 4'd8, 2'd2, 32'h0, 2'd2, 32'h0, 1'b1, 1'b0, 1'b1, w1);
         end
         begin
            for (int c = 1; c <= 6; c++) begin
               @(posedge clk);
               #1;
               hready = (c == 2) ? 1'b0 : 1'b1;
               hresp  = (c == 2 || c == 3) ? 1'b1 : 1'b0;
               @(negedge clk);
               if (c == 2) begin
                  chk("err_c2_htrans", 32'(htrans), 32'd2);
                  chk("err_c2_cmd_ready", 32'(cmd_ready), 32'd0);
               end
               if (c == 3) begin
                  chk("err_c3_htrans", 32'(htrans), 32'd0);
                  chk("err_c3_haddr", 32'(haddr), 32'd0);
                  chk("err_c3_hsel", 32'(hsel), 32'd1);
               end
               if (c == 4 || c == 5) begin
                  chk("err_rsp_valid", 32'(rsp_valid), 32'd1);
                  chk("err_rsp_error", 32'(rsp_error), 32'd1);
               end
               if (c == 6) begin
                  chk("err_c6_cmd_ready", 32'(cmd_ready), 32'd1);
                  chk("err_c6_busy", 32'(busy), 32'd0);
               end
            end
         end
      join
      drain();
      idle(2);

      // data-phase timeout with hready held low
      fork
         begin
            send(1'b0, 4'd1, 2'd2, 32'h0, 2'd2, 32'h0, 1'b1, 1'b1, 1'b1, w0);
         end
         begin
            for (int c = 1; c <= 7; c++) begin
               @(posedge clk);
               #1;
               hready = (c >= 2 && c <= 6) ? 1'b0 : 1'b1;
               @(negedge clk);
               if (c >= 2 && c <= 5) begin
                  chk("tmo_hsel_held", 32'(hsel), 32'd1);
                  chk("tmo_no_rsp", 32'(rsp_valid), 32'd0);
               end
               if (c == 6) begin
                  chk("tmo_rsp_valid", 32'(rsp_valid), 32'd1);
                  chk("tmo_rsp_error", 32'(rsp_error), 32'd1);
                  chk("tmo_hsel", 32'(hsel), 32'd0);
                  chk("tmo_htrans", 32'(htrans), 32'd0);
                  chk("tmo_busy", 32'(busy), 32'd0);
               end
            end
         end
      join
      drain();
      idle(2);

      // reset asserted in the middle of a write data phase
      send(1'b1, 4'd6, 2'd2, 32'h00000066, 2'd2, 32'h0, 1'b0, 1'b1, 1'b0, w0);
      @(posedge clk);
      #1;
      hready = 1'b0;
      #2;
      rst = 1'b1;
      #1;
      chk("mid_rst_htrans", 32'(htrans), 32'd0);
      chk("mid_rst_hsel", 32'(hsel), 32'd0);
      chk("mid_rst_haddr", 32'(haddr), 32'd0);
      chk("mid_rst_hwdata", hwdata, 32'h0);
      chk("mid_rst_busy", 32'(busy), 32'd0);
      chk("mid_rst_cmd_ready", 32'(cmd_ready), 32'd1);
      idle(1);
      hready = 1'b1;
      idle(1);
      rst = 1'b0;
      repeat (5) begin
         @(negedge clk);
         chk("post_rst_rsp_valid", 32'(rsp_valid), 32'd0);
      end
      drain();

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
      $finish;
   end

endmodule

// File: doc/ahb_master.md
# ahb_master

AHB-Lite single-transfer bus master that turns a simple command stream into NONSEQ transfers. It is the initiator counterpart of the endpoint's AHB-Lite slave register file and is used as the SoC-side driver in integration and as a bus-functional initiator in bench environments. Address and data phases are pipelined, so throughput is one transfer per cycle with zero wait states. Every accepted command gets exactly one response, in order, including error and timeout reporting.

## Interface
- ADDR_WIDTH, 4: width of haddr / cmd_addr
- TIMEOUT, 16: consecutive hready-low data-phase cycles before abort; 0 disables the timeout
- clk  in  1  system clock, all logic on rising edge
- rst  in  1  asynchronous, active-high reset
- cmd_valid  in  1  command present
- cmd_ready  out  1  command accepted on clk edge when cmd_valid & cmd_ready
- cmd_write  in  1  1 = write, 0 = read
- cmd_addr  in  ADDR_WIDTH  byte address, passed through unaligned
- cmd_size  in  2  0 = byte, 1 = halfword, 2 = word; 3 clamps to 2
- cmd_wdata  in  32  write data, little-endian lanes from bit 0
- rsp_valid  out  1  one-cycle response pulse
- rsp_rdata  out  32  read data (0 for writes and errors)
- rsp_error  out  1  transfer ended in hresp error, timeout, or cancellation
- busy  out  1  any transfer in address phase, data phase, or pending report
- hsel  out  1  slave select
- haddr  out  ADDR_WIDTH  address phase address
- htrans  out  2  2'b00 IDLE / 2'b10 NONSEQ only
- hsize  out  2  address phase size
- hwrite  out  1  address phase direction
- hburst  out  3  constant 3'b000 (SINGLE)
- hwdata  out  32  data phase write data
- hrdata  in  32  data phase read data
- hready  in  1  slave ready / phase advance
- hresp  in  1  slave error response

## Operation
- Two internal stages:
  - AP (address phase): valid, write, addr, size, wdata.
  - DP (data phase): valid, write, wdata.
- FSM states:
  - RUN
  - ERR (second error cycle pending)
  - CANCEL (report the cancelled AP command)
- Bus drive:
  - htrans = NONSEQ iff AP valid and state RUN; otherwise IDLE.
  - haddr, hsize and hwrite come from AP; they are 0 when AP is empty.
  - hsel = AP valid | DP valid. hsel stays high through the data phase, because the slave qualifies writes with hsel.
  - hwdata = DP wdata when DP is a valid write, else 0. It is held stable across wait states.
- Advance (RUN, hready = 1, hresp = 0):
  - DP ← AP.
  - AP ← the accepted command, or empty.
  - The completing DP produces rsp_valid in the next cycle. rsp_rdata is hrdata captured at that edge for reads, 0 for writes. rsp_error = 0.
- cmd_ready = state RUN & hresp = 0 & (AP empty | hready). It is combinational on hready and hresp.
- Wait states (hready = 0, hresp = 0): AP, DP and all bus outputs hold. The timeout counter increments while DP is valid and resets on any hready = 1.
- Error, first cycle (DP valid, hresp = 1, hready = 0):
  - Go to ERR.
  - The AP command, if any, is marked cancelled. Its htrans is forced IDLE from the next cycle, and AP address outputs are driven 0.
- ERR, second cycle (hresp = 1, hready = 1):
  - rsp_valid with rsp_error = 1 next cycle.
  - DP cleared.
  - Go to CANCEL if a command was cancelled, else RUN.
- CANCEL: one cycle. Emits rsp_valid with rsp_error = 1 and rsp_rdata = 0 for the cancelled command, then returns to RUN.
- Timeout (counter reaches TIMEOUT, TIMEOUT ≠ 0):
  - Abort DP with an error response.
  - Cancel AP exactly as in the error case.
  - Drive htrans IDLE and hsel 0 for one cycle.
- hresp = 1 with hready = 1 without a preceding first error cycle is treated as an error completion: rsp_error = 1, no cancel.
- Reset mid-transfer: all stages are cleared immediately. No response is emitted for in-flight commands.

## Timing
- Reset values:
  - htrans = 00, hsel = 0, haddr = 0, hsize = 0, hwrite = 0, hburst = 000, hwdata = 0.
  - rsp_valid = 0, rsp_rdata = 0, rsp_error = 0, busy = 0.
  - cmd_ready = 1 provided hresp = 0.
- Latency with zero wait states:
  - Accept at edge 0.
  - Address phase in cycle 1.
  - Data phase in cycle 2.
  - rsp_valid in cycle 3.
- Each wait state adds one cycle.
- Back-to-back commands: one accepted per cycle, one response per cycle, strictly in command order.
- Responses are never back-pressured. The consumer must sample every rsp_valid pulse.

## Test plan
- Write word 0xDEADBEEF at address 0, zero waits → htrans = 10, haddr = 0, hsize = 2 in cycle 1; hwdata = 0xDEADBEEF in cycle 2; rsp_valid = 1, rsp_error = 0 in cycle 3.
- Three back-to-back reads at 0, 4, 8 with hrdata = 0x11, 0x22, 0x33 → three consecutive rsp_valid pulses with rsp_rdata 0x11, 0x22, 0x33; cmd_ready stays high throughout.
- Write with 3 wait states (hready low cycles 2–4) → hwdata stable cycles 2–5, cmd_ready low during waits, rsp_valid in cycle 6.
- Write to 5 with hresp two-cycle error while a read of 8 is in AP → htrans IDLE in the second error cycle, then two responses, both rsp_error = 1; state returns to RUN with cmd_ready = 1.
- TIMEOUT = 4 with hready held low → rsp_error = 1 four cycles into the data phase, hsel = 0 and htrans IDLE for one cycle, busy returns to 0.
- Assert rst mid data phase → all outputs reach reset values asynchronously; no rsp_valid after rst deasserts.
